// File: rtl/maze_packet_rx_pkg.sv
// Shared types and field layout for the maze packet receiver.
// MAZE_PACKET_RX_PARITY_EN adds a trailing even-parity bit to each frame.
package maze_packet_rx_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_CHECK = 2'd2,
    ST_DROP  = 2'd3
  } rx_state_e;

  localparam int PAYLOAD_W = 16;
  localparam int X_LSB     = 13;
  localparam int X_W       = 3;
  localparam int Y_LSB     = 11;
  localparam int Y_W       = 2;
  localparam int RSV_LSB   = 8;
  localparam int RSV_W     = 3;
  localparam int TILE_LSB  = 0;
  localparam int TILE_W    = 8;

  localparam int MAX_X = 4;
  localparam int MAX_Y = 3;

  typedef enum logic [2:0] {
    TB_DONE     = 3'd0,
    TB_CURRENT  = 3'd1,
    TB_EXPLORED = 3'd2,
    TB_TOP      = 3'd3,
    TB_RIGHT    = 3'd4,
    TB_BOTTOM   = 3'd5,
    TB_LEFT     = 3'd6
  } tile_bit_e;

`ifdef MAZE_PACKET_RX_PARITY_EN
  localparam int FRAME_BITS = PAYLOAD_W + 1;
`else
  localparam int FRAME_BITS = PAYLOAD_W;
`endif

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/maze_packet_rx_sync_edge.sv
// Multi-flop synchronizer for one asynchronous input, with rise/fall strobes
// derived from the synchronized level and a one-cycle-delayed copy.
module maze_packet_rx_sync_edge #(
  parameter int STAGES = 2
) (
  input  logic CLK,
  input  logic RESET,
  input  logic d,
  output logic q,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] pipe;
  logic              prev;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      pipe <= '0;
      prev <= 1'b0;
    end else begin
      pipe <= {pipe[STAGES-2:0], d};
      prev <= pipe[STAGES-1];
    end
  end

  assign q    = pipe[STAGES-1];
  assign rise = q & ~prev;
  assign fall = ~q & prev;

endmodule

// File: rtl/maze_packet_rx.sv
// Serial maze-tile packet receiver: synchronizes the robot link, shifts a frame
// MSB first, validates it and publishes it. MAZE_PACKET_RX_PARITY_EN adds parity.
module maze_packet_rx
  import maze_packet_rx_pkg::*;
#(
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        SCLK_IN,
  input  logic        SDATA_IN,
  input  logic        SFRAME_IN,
  output logic [15:0] DATA_OUT,
  output logic        DATA_VAL,
  output logic        FRAME_ERR,
  output logic [7:0]  ERR_COUNT
);

  localparam int IN_SCLK   = 0;
  localparam int IN_SDATA  = 1;
  localparam int IN_SFRAME = 2;

  localparam int                  TMO_W       = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TMO_W-1:0]    TMO_LAST    = TMO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [2:0]          SETTLE_DONE = 3'(SYNC_STAGES + 1);
  localparam logic [4:0]          LEN_OK      = 5'(FRAME_BITS);
  localparam logic [X_W-1:0]      MAX_X_L     = MAX_X[X_W-1:0];
  localparam logic [Y_W:0]        MAX_Y_L     = MAX_Y[Y_W:0];

  logic [2:0] raw_in, sync_q, sync_rise, sync_fall;

  assign raw_in = {SFRAME_IN, SDATA_IN, SCLK_IN};

  maze_packet_rx_sync_edge #(.STAGES(SYNC_STAGES)) u_sync [2:0] (
    .CLK   (CLK),
    .RESET (RESET),
    .d     (raw_in),
    .q     (sync_q),
    .rise  (sync_rise),
    .fall  (sync_fall)
  );

  logic unused_sync;
  assign unused_sync = ^{sync_q[IN_SCLK], sync_fall[IN_SCLK],
                         sync_rise[IN_SDATA], sync_fall[IN_SDATA]};

  logic sclk_rise, sdata, sframe, sframe_rise, sframe_fall;
  assign sclk_rise   = sync_rise[IN_SCLK];
  assign sdata       = sync_q[IN_SDATA];
  assign sframe      = sync_q[IN_SFRAME];
  assign sframe_rise = sync_rise[IN_SFRAME];
  assign sframe_fall = sync_fall[IN_SFRAME];

  rx_state_e             state;
  logic [4:0]            bit_cnt;
  logic [FRAME_BITS-1:0] shreg;
  logic [TMO_W-1:0]      tmo_cnt;
  logic [2:0]            settle_cnt;
  logic                  settled;

  // The synchronizers come out of reset at 0, so a frame line that is
  // already high would look like a fresh rise; starts wait until they fill.
  assign settled = (settle_cnt == SETTLE_DONE);

  logic [PAYLOAD_W-1:0] payload;
  logic                 fields_ok, parity_ok, frame_ok;

  assign payload   = shreg[FRAME_BITS-1 -: PAYLOAD_W];
  assign fields_ok = (payload[X_LSB +: X_W] <= MAX_X_L) &&
                     ({1'b0, payload[Y_LSB +: Y_W]} <= MAX_Y_L) &&
                     (payload[RSV_LSB +: RSV_W] == '0);
`ifdef MAZE_PACKET_RX_PARITY_EN
  assign parity_ok = ~(^shreg);
`else
  assign parity_ok = 1'b1;
`endif
  assign frame_ok  = (bit_cnt == LEN_OK) && fields_ok && parity_ok;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state      <= ST_IDLE;
      bit_cnt    <= '0;
      shreg      <= '0;
      tmo_cnt    <= '0;
      settle_cnt <= '0;
      DATA_OUT   <= '0;
      DATA_VAL   <= 1'b0;
      FRAME_ERR  <= 1'b0;
      ERR_COUNT  <= '0;
    end else begin
      DATA_VAL  <= 1'b0;
      FRAME_ERR <= 1'b0;
      if (!settled) settle_cnt <= settle_cnt + 3'd1;

      case (state)
        ST_IDLE: begin
          if (sframe_rise && settled) begin
            state   <= ST_SHIFT;
            bit_cnt <= '0;
            shreg   <= '0;
            tmo_cnt <= '0;
          end
        end

        ST_SHIFT: begin
          if (sclk_rise) begin
            shreg   <= {shreg[FRAME_BITS-2:0], sdata};
            tmo_cnt <= '0;
            if (bit_cnt != 5'd31) bit_cnt <= bit_cnt + 5'd1;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
          // A bit arriving with the frame fall is shifted above before CHECK.
          if (sframe_fall) begin
            state <= ST_CHECK;
          end else if (!sclk_rise && tmo_cnt == TMO_LAST) begin
            state     <= ST_DROP;
            FRAME_ERR <= 1'b1;
            ERR_COUNT <= sat_inc8(ERR_COUNT);
          end
        end

        ST_CHECK: begin
          if (frame_ok) begin
            DATA_OUT <= payload;
            DATA_VAL <= 1'b1;
            state    <= ST_IDLE;
          end else begin
            state     <= ST_DROP;
            FRAME_ERR <= 1'b1;
            ERR_COUNT <= sat_inc8(ERR_COUNT);
          end
        end

        ST_DROP: begin
          if (!sframe) state <= ST_IDLE;
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
